// File: rtl/muldiv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | muldiv_pkg                                                         |
// | Shared opcodes, FSM encoding and constants for muldiv_sequencer.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package muldiv_pkg;

  localparam int unsigned RV_XLEN = 32;

  // RV32M funct3 encodings
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [RV_XLEN-1:0] INT_MIN  = 32'h8000_0000;
  localparam logic [RV_XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_addsub.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | muldiv_addsub                                                      |
// | Unsigned W-bit adder/subtractor; carry=1 on subtract means a >= b. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module muldiv_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W:0]   w_full;
  logic [W-1:0] w_b_op;

  assign w_b_op = sub ? ~b : b;
  assign w_full = {1'b0, a} + {1'b0, w_b_op} + {{W{1'b0}}, sub};
  assign sum    = w_full[W-1:0];
  assign carry  = w_full[W];

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | muldiv_sequencer                                                   |
// | Iterative RV32M multiply/divide unit, one add/sub step per cycle.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN  = RV_XLEN,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out
);

  localparam int CNT_W = $clog2(XLEN);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2:0]         r_op;
  logic [XLEN-1:0]    r_a;
  logic [XLEN-1:0]    r_hi;
  logic [XLEN-1:0]    r_lo;
  logic               r_neg_a;
  logic               r_neg_b;
  logic [CNT_W-1:0]   r_cnt;
  logic [XLEN-1:0]    r_result;
  logic [TAG_W-1:0]   r_tag;
  logic [TAG_W-1:0]   r_tag_out;

  logic               w_is_div;
  logic               w_sgn_a_op;
  logic               w_sgn_b_op;
  logic               w_neg_a;
  logic               w_neg_b;
  logic               w_div0;
  logic               w_ovf;
  logic               w_special;
  logic [XLEN-1:0]    w_spec_res;
  logic [XLEN:0]      w_shift;
  logic [XLEN:0]      w_add_a;
  logic [XLEN:0]      w_add_b;
  logic [XLEN:0]      w_sum;
  logic               w_carry;
  logic [XLEN:0]      w_acc;
  logic [2*XLEN-1:0]  w_prod;
  logic [2*XLEN-1:0]  w_prod_fix;
  logic [XLEN-1:0]    w_quot_fix;
  logic [XLEN-1:0]    w_rem_fix;
  logic [XLEN-1:0]    w_fix_res;
  logic [XLEN-1:0]    w_fin_res;

  assign ready   = (r_state == ST_IDLE);
  assign busy    = ~ready;
  assign done    = (r_state == ST_DONE);
  assign result  = r_result;
  assign tag_out = r_tag_out;

  // In PREP, r_lo still holds raw rs1 and r_a raw rs2.
  assign w_is_div   = r_op[2];
  assign w_sgn_a_op = (r_op == OP_MULH) || (r_op == OP_MULHSU) ||
                      (r_op == OP_DIV)  || (r_op == OP_REM);
  assign w_sgn_b_op = (r_op == OP_MULH) || (r_op == OP_DIV) || (r_op == OP_REM);
  assign w_neg_a    = w_sgn_a_op & r_lo[XLEN-1];
  assign w_neg_b    = w_sgn_b_op & r_a[XLEN-1];
  assign w_div0     = w_is_div && (r_a == '0);
  assign w_ovf      = ((r_op == OP_DIV) || (r_op == OP_REM)) &&
                      (r_lo == XLEN'(INT_MIN)) && (r_a == XLEN'(ALL_ONES));
  assign w_special  = w_div0 | w_ovf;

  always_comb begin
    w_spec_res = '0;
    if (w_div0)
      w_spec_res = r_op[1] ? r_lo : XLEN'(ALL_ONES);
    else
      w_spec_res = r_op[1] ? '0 : XLEN'(INT_MIN);
  end

  // Shared datapath: accumulate for multiply, trial subtract for divide.
  assign w_shift = {r_hi, r_lo[XLEN-1]};
  assign w_add_a = w_is_div ? w_shift : {1'b0, r_hi};
  assign w_add_b = {1'b0, r_a};

  muldiv_addsub #(
    .W (XLEN + 1)
  ) u_addsub (
    .a     (w_add_a),
    .b     (w_add_b),
    .sub   (w_is_div),
    .sum   (w_sum),
    .carry (w_carry)
  );

  assign w_acc = r_lo[0] ? w_sum : {1'b0, r_hi};

  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
  assign w_quot_fix = (r_neg_a ^ r_neg_b) ? -r_lo : r_lo;
  assign w_rem_fix  = r_neg_a ? -r_hi : r_hi;

  always_comb begin
    w_fix_res = '0;
    case (r_op)
      OP_MUL:                      w_fix_res = w_prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             w_fix_res = w_quot_fix;
      default:                     w_fix_res = w_rem_fix;
    endcase
  end

  assign w_fin_res = (r_state == ST_PREP) ? w_spec_res : w_fix_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start && !flush) w_state_nxt = ST_PREP;
      ST_PREP: begin
        if (flush)          w_state_nxt = ST_IDLE;
        else if (w_special) w_state_nxt = ST_DONE;
        else                w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (flush)              w_state_nxt = ST_IDLE;
        else if (r_cnt == '0)   w_state_nxt = ST_FIX;
      end
      ST_FIX:  w_state_nxt = flush ? ST_IDLE : ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= '0;
      r_a       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_neg_a   <= 1'b0;
      r_neg_b   <= 1'b0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_tag     <= '0;
      r_tag_out <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && !flush) begin
            r_op  <= op;
            r_lo  <= rs1;
            r_a   <= rs2;
            r_tag <= tag_in;
          end
        end
        ST_PREP: begin
          r_neg_a <= w_neg_a;
          r_neg_b <= w_neg_b;
          r_lo    <= w_neg_a ? -r_lo : r_lo;
          r_a     <= w_neg_b ? -r_a : r_a;
          r_hi    <= '0;
          r_cnt   <= CNT_W'(XLEN - 1);
        end
        ST_RUN: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_is_div) begin
            // A set carry means the shifted remainder covers the divisor.
            r_hi <= w_carry ? w_sum[XLEN-1:0] : w_shift[XLEN-1:0];
            r_lo <= {r_lo[XLEN-2:0], w_carry};
          end else begin
            r_hi <= w_acc[XLEN:1];
            r_lo <= {w_acc[0], r_lo[XLEN-1:1]};
          end
        end
        default: ;
      endcase
      if (w_state_nxt == ST_DONE) begin
        r_result  <= w_fin_res;
        r_tag_out <= r_tag;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_muldiv_sequencer                                                |
// | Directed self-checking bench for muldiv_sequencer.                 |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_muldiv_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [4:0]  tag_in;
  logic        flush;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  tag_out;

  int n_vec  = 0;
  int n_miss = 0;

  muldiv_sequencer #(
    .XLEN  (32),
    .TAG_W (5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .rs1     (rs1),
    .rs2     (rs2),
    .tag_in  (tag_in),
    .flush   (flush),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .tag_out (tag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request when ready; returns #1 after the accept edge.
  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t, input bit hold);
    int k;
    k = 0;
    @(negedge clk);
    while (!ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("ready timeout", 32'd0, 32'd1);
    start  = 1'b1;
    op     = o;
    rs1    = a;
    rs2    = b;
    tag_in = t;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t, input int lat, input logic [31:0] exp,
                       input string name, input bit hold);
    int n;
    bit rdy_bad;
    n       = 0;
    rdy_bad = 1'b0;
    launch(o, a, b, t, hold);
    while (!done && n < 100) begin
      if (ready) rdy_bad = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    chk({name, " latency"}, n, lat);
    chk({name, " result"}, result, exp);
    chk({name, " tag"}, {27'd0, tag_out}, {27'd0, t});
    chk({name, " ready low"}, {31'd0, rdy_bad | ready}, 32'd0);
  endtask

  task automatic watch_no_done(input int cycles, input string name);
    bit seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk(name, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    op     = 3'b000;
    rs1    = 32'd0;
    rs2    = 32'd0;
    tag_in = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready",  {31'd0, ready}, 32'd1);
    chk("rst busy",   {31'd0, busy},  32'd0);
    chk("rst done",   {31'd0, done},  32'd0);
    chk("rst result", result, 32'd0);
    chk("rst tag",    {27'd0, tag_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(3'b000, 32'd7,         32'hFFFF_FFFD, 5'd3,  34, 32'hFFFF_FFEB, "mul", 1'b0);
    do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd4,  34, 32'h4000_0000, "mulh", 1'b0);
    do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  34, 32'hFFFF_FFFE, "mulhu", 1'b0);
    do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  34, 32'hFFFF_FFFF, "mulhsu", 1'b0);
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2,         5'd7,  34, 32'hFFFF_FFFD, "div", 1'b0);
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2,         5'd8,  34, 32'hFFFF_FFFF, "rem", 1'b0);
    do_op(3'b101, 32'd100,       32'd7,         5'd10, 34, 32'd14,        "divu", 1'b0);
    do_op(3'b111, 32'd100,       32'd7,         5'd11, 34, 32'd2,         "remu", 1'b0);

    do_op(3'b101, 32'd5,         32'd0,         5'd12, 1, 32'hFFFF_FFFF, "divu by 0", 1'b0);
    do_op(3'b110, 32'd5,         32'd0,         5'd13, 1, 32'd5,         "rem by 0", 1'b0);
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1, 32'h8000_0000, "div ovf", 1'b0);
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1, 32'd0,         "rem ovf", 1'b0);

    // start held across the whole operation must give exactly one result
    do_op(3'b000, 32'd5, 32'd6, 5'd16, 34, 32'd30, "hold", 1'b1);
    watch_no_done(40, "hold single accept");
    chk("hold ready", {31'd0, ready}, 32'd1);

    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    op    = 3'b000;
    @(posedge clk);
    #1;
    chk("start+flush idle", {31'd0, ready}, 32'd1);
    start = 1'b0;
    flush = 1'b0;

    launch(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 5'd18, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush to idle", {31'd0, ready}, 32'd1);
    watch_no_done(40, "flush no done");
    chk("flush keeps result", result, 32'd30);
    do_op(3'b000, 32'd3, 32'd4, 5'd9, 34, 32'd12, "mul after flush", 1'b0);

    launch(3'b101, 32'd1000, 32'd3, 5'd17, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst ready",  {31'd0, ready}, 32'd1);
    chk("midrst busy",   {31'd0, busy},  32'd0);
    chk("midrst done",   {31'd0, done},  32'd0);
    chk("midrst result", result, 32'd0);
    chk("midrst tag",    {27'd0, tag_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_done(50, "midrst no done");

    do_op(3'b101, 32'd9, 32'd3, 5'd20, 34, 32'd3, "b2b divu", 1'b0);
    @(posedge clk);
    #1;
    chk("b2b ready after done", {31'd0, ready}, 32'd1);
    do_op(3'b111, 32'd9, 32'd4, 5'd21, 34, 32'd1, "b2b remu", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multi-cycle execution unit for the RV32M instructions MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Sits in the EX stage beside the ALU. Uses one shared add/subtract datapath, one iteration per cycle.
- Provides a ready/start/done handshake to the hazard unit, which stalls the pipeline while the block is busy.
- Takes a flush input so a squashed instruction can be aborted.

Parameters:
- XLEN, 32, operand and result width.
- TAG_W, 5, width of the destination-register tag carried through with the operation.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted on an edge where start=1, ready=1 and flush=0.
- op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  in  XLEN  operand A / dividend.
- rs2  in  XLEN  operand B / divisor.
- tag_in  in  TAG_W  destination register index.
- flush  in  1  synchronous abort.
- ready  out  1  high only in IDLE.
- busy  out  1  equals not ready.
- done  out  1  one-cycle result-valid pulse.
- result  out  XLEN  result value.
- tag_out  out  TAG_W  tag of the completed operation.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, ready=1, busy=0, done=0.
  - result=0, tag_out=0, all internal registers 0.
  - Reset applied mid-operation discards the operation; no done is produced.
- FSM states: IDLE, PREP, RUN, FIX, DONE.
- IDLE:
  - On accept, latch op, rs1, rs2 and tag_in, then go to PREP.
  - start while not ready is ignored; the requester must hold it.
- PREP (1 cycle):
  - Record operand signs per op. MULH, DIV and REM: both operands signed. MULHSU: rs1 signed only. Other ops: unsigned.
  - Replace each signed operand with its magnitude.
  - Load the iteration counter with XLEN-1 and clear the accumulator.
  - Special cases go straight to DONE with the final result. Otherwise go to RUN.
    - Divide by zero (rs2=0, DIV/DIVU/REM/REMU): quotient = all ones; remainder = original rs1.
    - Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- RUN (exactly XLEN cycles; counter decrements; exit to FIX when the counter is 0):
  - Multiply, unsigned shift-add:
    - {acc, mplr} is a 2*XLEN register.
    - If the mplr LSB is 1, add the multiplicand into acc using an XLEN+1-bit sum.
    - Shift the whole register right by 1, with the carry entering the MSB.
  - Divide, restoring:
    - Shift {rem, quot} left by 1.
    - Trial subtract rem-divisor on XLEN+1 bits.
    - If the result is non-negative, keep it and set the quot LSB to 1; otherwise restore and set it to 0.
- FIX (1 cycle):
  - Multiply: negate the 2*XLEN product when the recorded operand signs differ.
  - Divide: negate the quotient when the signs differ (signed ops only); give the remainder the sign of the dividend.
  - Select the result: low word for MUL, high word for MULH/MULHSU/MULHU, quotient for DIV/DIVU, remainder for REM/REMU.
- DONE (1 cycle):
  - done=1 with result and tag_out valid.
  - Next edge goes to IDLE.
  - result and tag_out hold their values until the next DONE.
- Latency, counted from the accept edge t0:
  - Normal operation: done is high in the cycle after edge t0+XLEN+2 (34 edges for XLEN=32).
  - Special case: done is high in the cycle after edge t0+1.
  - A new start may be accepted on the edge that leaves DONE, because ready is high in the following cycle.
- Flush:
  - In PREP, RUN or FIX: the next edge goes to IDLE and no done is produced.
  - Flush while in DONE: done still completes; the consumer is responsible for squashing it.
  - start and flush high together in IDLE: flush wins and nothing is accepted.
- Arithmetic rules:
  - All internal adders are unsigned.
  - Sign handling happens only in PREP and FIX.
  - Every result wraps modulo 2^XLEN.

Decomposition:
- Package muldiv_pkg holds:
  - Op funct3 localparams (OP_MUL … OP_REMU).
  - FSM state encoding.
  - Helper constants INT_MIN and ALL_ONES.
- Sub-module muldiv_addsub: XLEN+1-bit adder/subtractor (a, b, sub → sum, carry).
  - The same instance serves multiply accumulation and divide trial subtraction.
  - The FIX-stage negation uses separate logic.

Test Plan:
- MUL 7 × 0xFFFFFFFD → result 0xFFFFFFEB. done exactly 34 edges after accept. ready low throughout.
- High-word multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide: DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2. tag_out equals the tag captured at accept.
- Special cases:
  - DIVU 5/0 → 0xFFFFFFFF. REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same operands → 0.
  - For all four, done is high in the cycle after edge t0+1.
- Abort and reset:
  - flush at RUN cycle 10 → IDLE next edge, no done; a following MUL 3×4 returns 12.
  - rst_n low at RUN cycle 20 → all outputs at reset values immediately, no done.
- Handshake and back-to-back:
  - start held while busy is not accepted twice.
  - start and flush together in IDLE → not accepted.
  - Back-to-back DIVU 9/3 then REMU 9/4 → 3 then 1, second accept on the edge leaving DONE.
